// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler: builds one scanline of sprites by sharing one ROM port across all slots
//  Clk, Reset_n                 clock, async active-low reset
//  LineStart, NextLine          start pulse and scanline to build
//  SpriteX/Y/En/Flip            packed per-slot position, enable, mirror
//  RomSel, RomAddr -> RomData   ROM port, data one cycle after address
//  LbWe, LbAddr, LbData         line-buffer writes of opaque pixels
//  Busy, Done                   build in progress, completion pulse
module sprite_line_scheduler #(
   parameter int          NUM_SPRITES = 4,
   parameter int          LINE_WIDTH  = 640,
   parameter logic [23:0] TRANS_KEY   = 24'hFFD700,
   localparam int         SW          = $clog2(NUM_SPRITES)
) (
   input  logic                     Clk,
   input  logic                     Reset_n,
   input  logic                     LineStart,
   input  logic [9:0]               NextLine,
   input  logic [10*NUM_SPRITES-1:0] SpriteX,
   input  logic [10*NUM_SPRITES-1:0] SpriteY,
   input  logic [NUM_SPRITES-1:0]   SpriteEn,
   input  logic [NUM_SPRITES-1:0]   SpriteFlip,
   output logic [SW-1:0]            RomSel,
   output logic [7:0]               RomAddr,
   input  logic [23:0]              RomData,
   output logic                     LbWe,
   output logic [9:0]               LbAddr,
   output logic [23:0]              LbData,
   output logic                     Busy,
   output logic                     Done
);
   typedef enum logic [1:0] {IDLE, SCAN, FETCH, DONE} state_t;
   state_t state, state_nx;
   logic [9:0]               line_q;
   logic [10*NUM_SPRITES-1:0] x_q, y_q;
   logic [NUM_SPRITES-1:0]   en_q, flip_q;
   logic [SW-1:0]            slot;
   logic [4:0]               cnt;
   logic [3:0]               row;
   logic [9:0]               cur_x, cur_y, d;
   logic                     cur_en, cur_flip, hit, last, fetch, rd, px_ok;
   logic [10:0]              px_x;
   always_comb begin
      cur_x = '0;
      cur_y = '0;
      cur_en = 1'b0;
      cur_flip = 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++)
         if (slot == SW'(i)) begin
            cur_x = x_q[10*i +: 10];
            cur_y = y_q[10*i +: 10];
            cur_en = en_q[i];
            cur_flip = flip_q[i];
         end
   end
   assign d    = line_q - cur_y;
   assign hit  = cur_en && line_q >= cur_y && d < 10'd16;
   assign last = slot == '0;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = LineStart ? SCAN : IDLE;
         SCAN:    state_nx = hit ? FETCH : last ? DONE : SCAN;
         FETCH:   state_nx = cnt == 5'd16 ? (last ? DONE : SCAN) : FETCH;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) begin
         line_q <= '0;
         x_q <= '0;
         y_q <= '0;
         en_q <= '0;
         flip_q <= '0;
         slot <= '0;
         cnt <= '0;
         row <= '0;
      end else
         case (state)
            IDLE: if (LineStart) begin
               line_q <= NextLine;
               x_q <= SpriteX;
               y_q <= SpriteY;
               en_q <= SpriteEn;
               flip_q <= SpriteFlip;
               slot <= SW'(NUM_SPRITES - 1);
            end
            SCAN: if (hit) begin
               cnt <= '0;
               row <= d[3:0];
            end else slot <= slot - 1'b1;
            FETCH: if (cnt == 5'd16) slot <= slot - 1'b1;
               else cnt <= cnt + 1'b1;
            default: ;
         endcase
   // Fetch cycle cnt issues column cnt; the pixel returned in that cycle belongs to column cnt-1.
   assign fetch   = state == FETCH;
   assign rd      = fetch && !cnt[4];
   assign RomSel  = rd ? slot : '0;
   assign RomAddr = rd ? {row, cur_flip ? ~cnt[3:0] : cnt[3:0]} : '0;
   assign px_x    = {1'b0, cur_x} + 11'(cnt - 5'd1);
   assign px_ok   = fetch && cnt != '0 && RomData != TRANS_KEY && px_x < 11'(LINE_WIDTH);
   assign LbWe    = px_ok;
   assign LbAddr  = px_ok ? px_x[9:0] : '0;
   assign LbData  = px_ok ? RomData : '0;
   assign Busy    = state == SCAN || state == FETCH;
   assign Done    = state == DONE;
endmodule
